// File: rtl/line_memory_responder.sv
// Line-granular memory responder: one 256-bit line transaction at a time, fixed ack latency.
// Optional requester protocol checking is built when LINE_MEM_PROTOCOL_CHECK_EN is defined.
module line_memory_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o,
  output logic         protocol_err_o
);

  // state | meaning
  // IDLE  | waiting for enable_i; accepts and latches a request
  // BUSY  | latency countdown; inputs ignored
  // ACK   | one-cycle completion strobe; array access happened on entry

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [255:0]       rdata_q, rdata_d;

  logic [255:0]       mem [DEPTH];
  logic [IDX_W-1:0]   addr_idx;
  logic               go_ack;
  logic               op_wr;
  logic [IDX_W-1:0]   op_idx;
  logic [255:0]       op_data;
  logic               mem_we;

  logic               unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  assign addr_idx = addr_i[IDX_W+4:5];

  // With LATENCY=1 the array is accessed on the acceptance edge, before the latches hold the request.
  assign op_wr   = (state_q == ST_IDLE) ? write_i  : wr_q;
  assign op_idx  = (state_q == ST_IDLE) ? addr_idx : idx_q;
  assign op_data = (state_q == ST_IDLE) ? data_i   : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    go_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          wr_d    = write_i;
          idx_d   = addr_idx;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = ST_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (go_ack && !op_wr) begin
      rdata_d = mem[op_idx];
    end
  end

  assign mem_we = go_ack && op_wr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents deliberately survive reset; reset only suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[op_idx] <= op_data;
    end
  end

  assign ack_o  = (state_q == ST_ACK);
  assign busy_o = (state_q != ST_IDLE);
  assign data_o = rdata_q;

`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q;
    if ((state_q == ST_BUSY) &&
        (!enable_i || (addr_idx != idx_q) || (write_i != wr_q))) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign protocol_err_o = proto_err_q;
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench for line_memory_responder: directed corner cases plus randomized
// transactions against a line-indexed reference memory; a LATENCY=1 instance covers back-to-back acks.
module tb_line_memory_responder;

  localparam int L0 = 10;
  localparam int D0 = 512;
  localparam int D1 = 16;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  localparam bit PE_EXP = 1'b1;
`else
  localparam bit PE_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, wr;
  logic [31:0]  addr;
  logic [255:0] din, dout;
  logic         ack, busy, perr;

  logic         rst1, en1, wr1;
  logic [31:0]  addr1;
  logic [255:0] din1, dout1;
  logic         ack1, busy1, perr1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [255:0] model_mem [int];
  logic [255:0] model_dout;

  always #5 clk = ~clk;

  line_memory_responder #(.LATENCY(L0), .DEPTH(D0)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr), .data_i(din),
    .ack_o(ack), .data_o(dout), .busy_o(busy), .protocol_err_o(perr)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH(D1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .enable_i(en1), .write_i(wr1), .addr_i(addr1), .data_i(din1),
    .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .protocol_err_o(perr1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_dout = '0;
  endtask

  // mode: 0 quiet, 1 scramble data_i in BUSY, 2 also scramble addr_i/write_i, 3 drop enable_i
  task automatic txn(input bit w, input logic [31:0] a, input logic [255:0] d, input int mode);
    int ack_at;
    int n_ack;
    int line;
    logic [255:0] d_ack;
    line   = int'((a >> 5) % D0);
    ack_at = -1;
    n_ack  = 0;
    d_ack  = '0;
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    for (int j = 0; j <= L0 + 2; j++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = j;
          d_ack  = dout;
        end
        en = 1'b0;
      end else if (j < L0) begin
        if (j == 0) chk("busy_after_accept", 256'(busy), 256'(1));
        if (mode >= 1) din = rand256();
        if (mode == 2) begin
          addr = $urandom;
          wr   = ~wr;
        end
        if (mode == 3) en = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("ack_latency", 256'(ack_at), 256'(L0));
    chk("ack_count", 256'(n_ack), 256'(1));
    chk("busy_after_done", 256'(busy), 256'(0));
    if (w) begin
      chk("dout_during_write_ack", d_ack, model_dout);
      model_mem[line] = d;
    end else begin
      chk("read_data", d_ack, model_mem[line]);
      model_dout = model_mem[line];
    end
    chk("dout_hold", dout, model_dout);
  endtask

  initial begin
    logic [255:0] v, v1, v2;
    logic [31:0]  a;
    int           n;
    int           prev;
    int           bad_gap;
    bit           seen [16];

    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rst1 = 1'b1; en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    model_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 256'(ack), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_dout", dout, 256'(0));
    chk("rst_err", 256'(perr), 256'(0));
    chk("rst_ack1", 256'(ack1), 256'(0));
    rst = 1'b0;
    rst1 = 1'b0;

    // line 2 via 0x40
    v = rand256();
    txn(1'b1, 32'h40, v, 1);
    txn(1'b0, 32'h40, rand256(), 1);
    chk("line2_read", dout, v);

    // 0xA5 pattern write then read
    txn(1'b1, 32'h1000, {32{8'hA5}}, 0);
    txn(1'b0, 32'h1000, rand256(), 0);
    chk("a5_read", dout, {32{8'hA5}});

    // address wrap and ignored offset bits
    v = rand256();
    txn(1'b1, 32'h4020, v, 1);
    txn(1'b0, 32'h0020, '0, 0);
    chk("wrap_read", dout, v);
    txn(1'b0, 32'h003F, '0, 0);
    chk("wrap_read_1f", dout, v);

    // reset at edge 5 of a write to line 7
    v1 = rand256();
    txn(1'b1, 32'hE0, v1, 0);
    v2 = ~v1;
    en = 1'b1; wr = 1'b1; addr = 32'hE0; din = v2;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ack", 256'(ack), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_dout", dout, 256'(0));
    rst = 1'b0;
    en = 1'b0;
    model_dout = '0;
    n = 0;
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
      if (ack === 1'b1) n++;
    end
    chk("abort_no_late_ack", 256'(n), 256'(0));
    txn(1'b0, 32'hE0, '0, 0);
    chk("abort_line7_kept", dout, v1);

    // randomized traffic over a small line pool with aliasing high bits
    for (int i = 0; i < 24; i++) begin
      int  ln;
      bit  w;
      ln = int'($urandom_range(16, 31));
      w  = !model_mem.exists(ln) || ($urandom_range(0, 1) == 1);
      a  = (32'($urandom_range(0, 7)) << 14) | (32'(ln) << 5) | 32'($urandom_range(0, 31));
      txn(w, a, rand256(), 1);
    end
    chk("err_clean_traffic", 256'(perr), 256'(0));

    // input changes in BUSY: no effect on transaction, flagged when checking is built
    v = rand256();
    txn(1'b1, 32'h60, v, 2);
    chk("err_addr_change", 256'(perr), 256'(PE_EXP));
    pulse_reset();
    chk("err_cleared", 256'(perr), 256'(0));
    txn(1'b0, 32'h60, '0, 3);
    chk("scrambled_write_intact", dout, v);
    chk("err_enable_drop", 256'(perr), 256'(PE_EXP));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 256'(perr), 256'(PE_EXP));
    pulse_reset();
    chk("err_cleared2", 256'(perr), 256'(0));

    // LATENCY=1 with enable held high
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = $urandom;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      seen[k] = (ack1 === 1'b1);
      @(posedge clk);
    end
    en1 = 1'b0;
    n = 0;
    prev = -1;
    bad_gap = 0;
    for (int k = 0; k < 16; k++) begin
      if (seen[k]) begin
        n++;
        if (prev >= 0 && (k - prev) != 2) bad_gap++;
        prev = k;
      end
    end
    chk("lat1_ack_count", 256'(n), 256'(8));
    chk("lat1_ack_spacing", 256'(bad_gap), 256'(0));
    chk("lat1_err", 256'(perr1), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
